// File: rtl/bitlet_pkg.sv
// Shared constants, types and scheduler state encoding for the Bitlet weight scheduler.
// Widths here must agree with the parameters of bitlet_weight_scheduler.
// No ports; imported by lsb_priority_encoder and bitlet_weight_scheduler.
package bitlet_pkg;

   localparam int BITLET_DATA_WIDTH = 8;
   localparam int BITLET_VEC_LENGTH = 32;
   localparam int BITLET_SEL_WIDTH  = 5;

   typedef logic [BITLET_DATA_WIDTH-1:0] weight_t;
   typedef logic [BITLET_SEL_WIDTH-1:0]  sel_t;
   typedef logic [BITLET_VEC_LENGTH-1:0] plane_mask_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } sched_state_t;

endpackage

// File: rtl/lsb_priority_encoder.sv
// Finds the lowest set bit of one bit-plane mask; purely combinational, no latency.
// Ports: mask (plane_mask_t) in; index (sel_t), found, clr (one-hot of the lowest set bit) out.
// No handshake; index and clr are zero when the mask is empty.
module lsb_priority_encoder
   import bitlet_pkg::*;
(
   input  plane_mask_t mask,
   output sel_t        index,
   output logic        found,
   output plane_mask_t clr
);

   always_comb begin
      index = '0;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = BITLET_VEC_LENGTH - 1; i >= 0; i--) begin
         if (mask[i]) index = sel_t'(i);
      end
   end

   assign found = |mask;
   // Two's-complement trick isolates the lowest set bit.
   assign clr   = mask & (~mask + plane_mask_t'(1));

endmodule

// File: rtl/bitlet_weight_scheduler.sv
// Splits a tile of weights into bit planes and issues, per cycle, the next activation index per plane.
// Latency: tile accepted in cycle N issues first in N+1; drains in max(1, max plane popcount) cycles.
// Backpressure: out_ready low holds masks/outputs; w_ready only when idle or on the tile's last fire.
// Ports: clk, reset (async active-low); w_in/w_first/w_valid/w_ready tile input;
//        act_sel/act_val/load_accum/out_valid/out_ready/tile_last issue output.
// Optional macro BITLET_SCHED_STATS_EN adds stat_cycles and stat_idle_lanes counters.
module bitlet_weight_scheduler
   import bitlet_pkg::*;
#(
   parameter int DATA_WIDTH    = BITLET_DATA_WIDTH,
   parameter int VEC_LENGTH    = BITLET_VEC_LENGTH,
   parameter int MUX_SEL_WIDTH = BITLET_SEL_WIDTH
)
(
   input  logic                              clk,
   input  logic                              reset,
   input  logic [VEC_LENGTH*DATA_WIDTH-1:0]  w_in,
   input  logic                              w_first,
   input  logic                              w_valid,
   output logic                              w_ready,
   output logic [DATA_WIDTH*MUX_SEL_WIDTH-1:0] act_sel,
   output logic [DATA_WIDTH-1:0]             act_val,
   output logic                              load_accum,
   output logic                              out_valid,
   input  logic                              out_ready,
`ifdef BITLET_SCHED_STATS_EN
   output logic [31:0]                       stat_cycles,
   output logic [31:0]                       stat_idle_lanes,
`endif
   output logic                              tile_last
);

   sched_state_t state_q, state_d;
   plane_mask_t  mask_q [DATA_WIDTH];
   plane_mask_t  mask_d [DATA_WIDTH];
   plane_mask_t  clr    [DATA_WIDTH];
   sel_t         idx    [DATA_WIDTH];
   logic [DATA_WIDTH-1:0] found;
   logic [DATA_WIDTH-1:0] multi;
   logic         first_pend_q;
   logic         run;
   logic         last_int;
   logic         fire;
   logic         accept;

   for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_plane
      lsb_priority_encoder u_enc (
         .mask  (mask_q[j]),
         .index (idx[j]),
         .found (found[j]),
         .clr   (clr[j])
      );
      // More than one bit left in this plane means at least one more issue cycle.
      assign multi[j] = |(mask_q[j] & (mask_q[j] - plane_mask_t'(1)));
      assign act_sel[j*MUX_SEL_WIDTH +: MUX_SEL_WIDTH] = run ? idx[j] : '0;
      assign act_val[j] = run & found[j];
   end

   assign run        = (state_q == RUN);
   assign last_int   = ~|multi;
   assign tile_last  = run & last_int;
   assign load_accum = run & first_pend_q;
   assign fire       = out_valid & out_ready;
   assign accept     = w_valid & w_ready;

   always_comb begin
      state_d   = state_q;
      out_valid = 1'b0;
      w_ready   = 1'b0;
      case (state_q)
         IDLE: begin
            w_ready = 1'b1;
            if (accept) state_d = RUN;
         end
         RUN: begin
            out_valid = 1'b1;
            // Reloading on the final fire keeps the issue stream gap-free.
            w_ready   = last_int & out_ready;
            if (fire && last_int && !accept) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      for (int j = 0; j < DATA_WIDTH; j++) begin
         mask_d[j] = mask_q[j];
         if (accept) begin
            for (int i = 0; i < VEC_LENGTH; i++) mask_d[j][i] = w_in[i*DATA_WIDTH + j];
         end else if (fire) begin
            mask_d[j] = mask_q[j] & ~clr[j];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         first_pend_q <= 1'b0;
         for (int j = 0; j < DATA_WIDTH; j++) mask_q[j] <= '0;
      end else begin
         state_q <= state_d;
         for (int j = 0; j < DATA_WIDTH; j++) mask_q[j] <= mask_d[j];
         if (accept)    first_pend_q <= w_first;
         else if (fire) first_pend_q <= 1'b0;
      end
   end

`ifdef BITLET_SCHED_STATS_EN
   logic [31:0] idle_n;
   logic [32:0] cyc_sum;
   logic [32:0] idle_sum;

   always_comb begin
      idle_n = '0;
      for (int j = 0; j < DATA_WIDTH; j++) begin
         if (!act_val[j]) idle_n = idle_n + 32'd1;
      end
   end

   assign cyc_sum  = {1'b0, stat_cycles} + 33'd1;
   assign idle_sum = {1'b0, stat_idle_lanes} + {1'b0, idle_n};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_cycles     <= '0;
         stat_idle_lanes <= '0;
      end else if (fire) begin
         stat_cycles     <= cyc_sum[32]  ? '1 : cyc_sum[31:0];
         stat_idle_lanes <= idle_sum[32] ? '1 : idle_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_bitlet_weight_scheduler.sv
// Directed self-checking bench for bitlet_weight_scheduler.
// Inputs change and outputs are sampled on the falling clock edge.
// Define BITLET_SCHED_STATS_EN to also exercise the statistics counters.
module tb_bitlet_weight_scheduler;

   localparam int DW = 8;
   localparam int VL = 32;
   localparam int SW = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic [VL*DW-1:0] w_in;
   logic             w_first;
   logic             w_valid;
   logic             w_ready;
   logic [DW*SW-1:0] act_sel;
   logic [DW-1:0]    act_val;
   logic             load_accum;
   logic             out_valid;
   logic             out_ready;
   logic             tile_last;
`ifdef BITLET_SCHED_STATS_EN
   logic [31:0]      stat_cycles;
   logic [31:0]      stat_idle_lanes;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bitlet_weight_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .w_in       (w_in),
      .w_first    (w_first),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .act_sel    (act_sel),
      .act_val    (act_val),
      .load_accum (load_accum),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
`ifdef BITLET_SCHED_STATS_EN
      .stat_cycles     (stat_cycles),
      .stat_idle_lanes (stat_idle_lanes),
`endif
      .tile_last  (tile_last)
   );

   function automatic logic [SW-1:0] sel_of(input int j);
      return act_sel[j*SW +: SW];
   endfunction

   task automatic set_w(input int i, input logic [DW-1:0] v);
      w_in[i*DW +: DW] = v;
   endtask

   task automatic test_reset();
      reset = 1'b0; w_in = '0; w_first = 1'b0; w_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (w_ready !== 1'b1) begin bad++; $display("FAIL reset_w_ready got=%b want=1", w_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (act_val !== 8'h00) begin bad++; $display("FAIL reset_act_val got=%h want=00", act_val); end
      total++; if (act_sel !== '0) begin bad++; $display("FAIL reset_act_sel got=%h want=0", act_sel); end
      total++; if (load_accum !== 1'b0 || tile_last !== 1'b0) begin bad++;
         $display("FAIL reset_ctl got load=%b last=%b want 0 0", load_accum, tile_last); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      w_in = '0; set_w(3, 8'h01); set_w(9, 8'h01);
      w_first = 1'b1; w_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      w_valid = 1'b0; w_first = 1'b0;
      total++; if (out_valid !== 1'b1 || sel_of(0) !== 5'd3 || act_val !== 8'h01) begin bad++;
         $display("FAIL single_c1 got v=%b sel0=%0d val=%h want 1 3 01", out_valid, sel_of(0), act_val); end
      total++; if (load_accum !== 1'b1 || tile_last !== 1'b0) begin bad++;
         $display("FAIL single_c1_ctl got load=%b last=%b want 1 0", load_accum, tile_last); end
      @(negedge clk);
      total++; if (sel_of(0) !== 5'd9 || act_val !== 8'h01) begin bad++;
         $display("FAIL single_c2 got sel0=%0d val=%h want 9 01", sel_of(0), act_val); end
      total++; if (load_accum !== 1'b0 || tile_last !== 1'b1) begin bad++;
         $display("FAIL single_c2_ctl got load=%b last=%b want 0 1", load_accum, tile_last); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || w_ready !== 1'b1) begin bad++;
         $display("FAIL single_idle got v=%b rdy=%b want 0 1", out_valid, w_ready); end
   endtask

   task automatic test_dense();
      int errs;
      errs = 0;
      w_in = '1; w_first = 1'b0; w_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      w_valid = 1'b0;
      for (int k = 0; k < VL; k++) begin
         for (int j = 0; j < DW; j++) begin
            total++;
            if (sel_of(j) !== k[SW-1:0]) begin bad++;
               $display("FAIL dense_sel k=%0d j=%0d got=%0d want=%0d", k, j, sel_of(j), k); end
         end
         total++; if (act_val !== 8'hFF || out_valid !== 1'b1 || load_accum !== 1'b0) begin bad++;
            $display("FAIL dense_val k=%0d got val=%h v=%b load=%b want FF 1 0", k, act_val, out_valid, load_accum); end
         total++; if (tile_last !== (k == VL - 1)) begin bad++;
            $display("FAIL dense_last k=%0d got=%b want=%b", k, tile_last, (k == VL - 1)); end
         @(negedge clk);
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dense_idle got v=%b want 0", out_valid); end
   endtask

   task automatic test_zero();
      w_in = '0; w_first = 1'b1; w_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      w_valid = 1'b0; w_first = 1'b0;
      total++; if (out_valid !== 1'b1 || act_val !== 8'h00 || act_sel !== '0) begin bad++;
         $display("FAIL zero_issue got v=%b val=%h sel=%h want 1 00 0", out_valid, act_val, act_sel); end
      total++; if (load_accum !== 1'b1 || tile_last !== 1'b1) begin bad++;
         $display("FAIL zero_ctl got load=%b last=%b want 1 1", load_accum, tile_last); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_idle got v=%b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      w_in = '0; set_w(5, 8'h80); w_first = 1'b0; w_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      // Tile B (bits 0 and 1 at index 2) waits while A stalls.
      w_in = '0; set_w(2, 8'h03); w_first = 1'b1; w_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         total++; if (out_valid !== 1'b1 || sel_of(7) !== 5'd5 || act_val !== 8'h80) begin bad++;
            $display("FAIL b2b_stall c=%0d got v=%b sel7=%0d val=%h want 1 5 80", c, out_valid, sel_of(7), act_val); end
         total++; if (w_ready !== 1'b0 || load_accum !== 1'b0 || tile_last !== 1'b1) begin bad++;
            $display("FAIL b2b_stall_ctl c=%0d got rdy=%b load=%b last=%b want 0 0 1", c, w_ready, load_accum, tile_last); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      total++; if (w_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", w_ready); end
      @(negedge clk);
      w_valid = 1'b0; w_first = 1'b0;
      total++; if (out_valid !== 1'b1 || act_val !== 8'h03 || sel_of(0) !== 5'd2 || sel_of(1) !== 5'd2) begin bad++;
         $display("FAIL b2b_tile_b got v=%b val=%h sel0=%0d sel1=%0d want 1 03 2 2", out_valid, act_val, sel_of(0), sel_of(1)); end
      total++; if (load_accum !== 1'b1 || tile_last !== 1'b1) begin bad++;
         $display("FAIL b2b_tile_b_ctl got load=%b last=%b want 1 1", load_accum, tile_last); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got v=%b want 0", out_valid); end
   endtask

   task automatic test_reset_mid_run();
      w_in = '1; w_first = 1'b1; w_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      w_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || w_ready !== 1'b1 || act_val !== 8'h00) begin bad++;
         $display("FAIL midrst got v=%b rdy=%b val=%h want 0 1 00", out_valid, w_ready, act_val); end
      @(negedge clk);
      reset = 1'b1;
      w_in = '0; set_w(7, 8'h04); w_first = 1'b0; w_valid = 1'b1;
      @(negedge clk);
      w_valid = 1'b0;
      total++; if (act_val !== 8'h04 || sel_of(2) !== 5'd7 || tile_last !== 1'b1 || load_accum !== 1'b0) begin bad++;
         $display("FAIL midrst_fresh got val=%h sel2=%0d last=%b load=%b want 04 7 1 0", act_val, sel_of(2), tile_last, load_accum); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_idle got v=%b want 0", out_valid); end
   endtask

`ifdef BITLET_SCHED_STATS_EN
   task automatic test_stats();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      total++; if (stat_cycles !== 32'd0 || stat_idle_lanes !== 32'd0) begin bad++;
         $display("FAIL stats_reset got cyc=%0d idle=%0d want 0 0", stat_cycles, stat_idle_lanes); end
      w_in = '0; set_w(0, 8'h01); w_first = 1'b0; out_ready = 1'b1;
      for (int t = 0; t < 5; t++) begin
         w_valid = 1'b1;
         @(negedge clk);
         w_valid = 1'b0;
         @(negedge clk);
      end
      total++; if (stat_cycles !== 32'd5) begin bad++; $display("FAIL stats_cycles got=%0d want=5", stat_cycles); end
      total++; if (stat_idle_lanes !== 32'd35) begin bad++; $display("FAIL stats_idle got=%0d want=35", stat_idle_lanes); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_dense();
      test_zero();
      test_back_to_back();
      test_reset_mid_run();
`ifdef BITLET_SCHED_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bitlet_weight_scheduler.md
Name: bitlet_weight_scheduler

Overview:
Upstream stage of the 32-lane Bitlet MAC. Accepts one tile of VEC_LENGTH weights and decomposes it into bit planes. Each issue cycle it emits, for every bit significance j, the index of the next activation whose weight bit j is set (act_sel[j]) and a lane-valid flag (act_val[j]). It also generates the MAC's en and load_accum controls. The tile drains in max(1, max-over-planes popcount) cycles.

Parameters:
DATA_WIDTH, 8, weight width = number of bit planes = MAC adder lanes
VEC_LENGTH, 32, weights/activations per tile
MUX_SEL_WIDTH, $clog2(VEC_LENGTH), select index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
w_in  in  [DATA_WIDTH-1:0] x VEC_LENGTH  weight tile, raw two's-complement bits
w_first  in  1  tile starts a new accumulation (MAC loads accum_prev)
w_valid  in  1  tile present
w_ready  out  1  tile accepted when w_valid & w_ready
act_sel  out  [MUX_SEL_WIDTH-1:0] x DATA_WIDTH  per-plane activation index
act_val  out  1 x DATA_WIDTH  per-plane lane valid
load_accum  out  1  asserted on the first issue cycle of a w_first tile
out_valid  out  1  issue cycle present (drives MAC en through the output handshake)
out_ready  in  1  downstream accepts the issue cycle
tile_last  out  1  current issue cycle is the tile's last

Behaviour:
- State registers: mask[j][i] = w_in[i][j], latched on accept; first_pend (1 bit); state IDLE/RUN.
- Reset (reset=0, asynchronous): state=IDLE, all masks=0, first_pend=0. Outputs: w_ready=1; out_valid, act_val, act_sel, load_accum, tile_last all 0.
- IDLE: w_ready=1, out_valid=0. On accept, load the masks, set first_pend=w_first, and go to RUN.
- RUN: out_valid=1.
  - For each j: act_sel[j] = index of the lowest set bit of mask[j]; act_val[j] = |mask[j].
  - If act_val[j]=0, act_sel[j]=0.
- Outputs are combinational from registers only. There is no w_in→output or out_ready→act_* path.
- tile_last=1 when no plane has more than one set bit remaining. This includes the all-zero mask.
- load_accum = out_valid & first_pend.
- On fire (out_valid & out_ready):
  - Clear the selected bit in every valid plane.
  - Clear first_pend.
  - If tile_last: go to IDLE, unless a new tile is accepted in the same cycle.
- Back-to-back tiles: w_ready = IDLE | (RUN & tile_last & out_ready). Accepting on the last fire reloads the masks and stays in RUN with no bubble.
- Latency: tile accepted in cycle N → first out_valid in cycle N+1.
- All-zero tile: exactly one issue cycle with all act_val=0 and tile_last=1. load_accum follows w_first, so the MAC accumulator load still happens.
- Stall: while out_valid & !out_ready, masks and all outputs hold stable.
- Sign: plane DATA_WIDTH-1 is scheduled like any other plane. The MAC negates that lane; the scheduler does no arithmetic.
- Issue cycles per tile = max(1, max_j popcount(mask[j])). The range is 1..VEC_LENGTH.

Optional Feature:
BITLET_SCHED_STATS_EN
- Defined: adds outputs stat_cycles[31:0] and stat_idle_lanes[31:0].
  - stat_cycles counts fires.
  - stat_idle_lanes adds, per fire, the number of planes with act_val=0.
  - Both counters saturate at 2^32-1 and reset asynchronously to 0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package bitlet_pkg:
  - constants BITLET_DATA_WIDTH=8, BITLET_VEC_LENGTH=32, BITLET_SEL_WIDTH=5
  - typedefs weight_t, sel_t, plane_mask_t [VEC_LENGTH-1:0]
  - state enum sched_state_t {IDLE, RUN}
- Sub-module lsb_priority_encoder, instantiated DATA_WIDTH times:
  - input plane_mask_t
  - outputs sel_t index, found flag, one-hot clear mask

Test Plan:
- Reset-mid-RUN: during RUN, pull reset low → same cycle, out_valid=0, w_ready=1, act_val all 0. After release, the next tile schedules from fresh masks.
- Single tile: w_in[i]=8'h01 for i=3,9, all others 0, w_first=1, out_ready=1.
  - Cycle 1: act_sel[0]=3, act_val=8'h01, load_accum=1, tile_last=0.
  - Cycle 2: act_sel[0]=9, load_accum=0, tile_last=1.
  - Then IDLE.
- Dense tile: all 32 weights = 8'hFF → 32 issue cycles; in cycle k (k=0..31), act_sel[j]=k for every j and act_val=8'hFF; tile_last only on k=31.
- All-zero tile with w_first=1 → one cycle: act_val=0, load_accum=1, tile_last=1.
- Back-to-back with stall:
  - Tile A = one weight 8'h80 at index 5; tile B presented early.
  - Hold out_ready=0 for 3 cycles → act_sel[7]=5 stable, w_ready=0.
  - Raise out_ready → tile B accepted in the same cycle; B issues in the next cycle with no bubble.
- Macro build: 5 tiles of 8'h01 at index 0 → stat_cycles=5, stat_idle_lanes=35.
